grf_multiport_sb: RTL and testbench
===================================

Name: grf_multiport_sb

Overview:
- Parametrised general register file for the pipelined CPU. Successor to the fixed 32x32, 2-read-port GRF.
- Configurable data width, depth and read-port count. Keeps W-stage-to-D-stage internal forwarding and the hard-wired zero register.
- Adds a per-register pending scoreboard and an outstanding-write counter so D-stage hazard logic can stall on in-flight writers without decoding every downstream stage.
- Sits in D stage: D reads and issues; W writes back.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NRD, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd_addr  in  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data, combinational; port k at bits [k*DATA_W +: DATA_W].
- rd_pending  out  NRD  port k's register has an outstanding writer (combinational).
- issue_en  in  1  D stage issues an instruction that will write issue_addr.
- issue_addr  in  ADDR_W  destination of the issued instruction.
- we  in  1  W-stage write-back enable.
- wa  in  ADDR_W  write-back address.
- wd  in  DATA_W  write-back data.
- wpc  in  32  PC of the writing instruction; used only by the trace feature.
- pend_cnt  out  ADDR_W+1  number of registers currently marked pending (registered).

Behaviour:
- Reset (async, any time, including mid-write): all registers = 0, all pending bits = 0, pend_cnt = 0.
  - While reset is high, rd_data = 0 and rd_pending = 0 on every port; write and issue are ignored.
- Write: on posedge clk, if we && wa != 0, then reg[wa] <= wd. A write to register 0 is discarded.
- Read, port k, priority order:
  - rd_addr_k == 0 gives 0.
  - Else we && wa == rd_addr_k gives wd (same-cycle internal forwarding).
  - Else reg[rd_addr_k].
  - Every port is independent; all ports may hit the same address.
- Scoreboard, one pending bit per register; bit 0 is constantly 0.
  - set = issue_en && issue_addr != 0.
  - clr = we && wa != 0.
  - On posedge: set only marks pend[issue_addr] = 1.
  - Clear only marks pend[wa] = 0.
  - Set and clear on the same address in the same cycle: bit ends at 1 (the new writer wins).
  - Set and clear on different addresses: both take effect.
  - Clearing an already-clear bit is a no-op with no error.
- rd_pending_k = pend[rd_addr_k] && !(we && wa == rd_addr_k && wa != 0).
  - The write-back in the current cycle satisfies the hazard, so forwarded data is valid.
  - Exception: an issue to the same address in the same cycle re-sets the bit for the next cycle only.
- pend_cnt: registered popcount of the pending bits after the update.
  - Incremented by 1 when a 0->1 transition occurs.
  - Decremented by 1 when a 1->0 transition occurs.
  - Net change per cycle is in [-1, +1]; never wraps, maximum 2**ADDR_W - 1.
- Latency: write visible to reads the same cycle via forwarding; stored value visible from the next cycle. Pending bit visible the cycle after issue.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on each accepted write, at the clock edge, print `$display("%d@%h: $%d <= %h", $time, wpc, wa, wd)`.
  - Writes with wa == 0 are also printed, with data shown as 0, matching the existing trace format used by the comparison scripts.
- Undefined: no display statements are compiled; wpc is unused; functional behaviour is identical.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data = 0x00000000, rd_pending = 0, pend_cnt = 0.
- we=1, wa=5, wd=0x12345678 with rd_addr port0 = 5 in the same cycle -> port0 shows 0x12345678 that cycle and the next. Write to wa=0 with 0xFFFFFFFF -> reading $0 gives 0, and the trace line shows data 0.
- issue_en with issue_addr=8 -> next cycle rd_pending for $8 = 1 and pend_cnt = 1. Later we with wa=8 -> rd_pending = 0 during the write cycle, and pend_cnt = 0 after the edge.
- Same cycle: issue_addr=8, we with wa=8 while $8 is pending -> pend[8] stays 1 and pend_cnt unchanged. Same cycle with issue_addr=9, wa=8 -> pend[8]=0, pend[9]=1, pend_cnt unchanged.
- NRD=4: all four ports read $3, $0, $3, $31 while writing $31 = 0xA5A5A5A5 -> returns reg3, 0, reg3, 0xA5A5A5A5.
- Assert reset asynchronously between edges while pend_cnt = 3 -> outputs drop to 0 immediately, without waiting for a clock edge, and pend_cnt = 0.

Source files
------------

// File: rtl/grf_multiport_sb.sv
// rtl/grf_multiport_sb.sv - parametrised multi-read-port register file with pending-writer scoreboard
// Optional write-back trace enabled by defining GRF_TRACE_EN.
module grf_multiport_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_pending,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [31:0]              wpc,
    output logic [ADDR_W:0]          pend_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              set_ok;
    logic              clr_ok;
    logic              cnt_inc;
    logic              cnt_dec;

    assign set_ok = issue_en && (issue_addr != '0);
    assign clr_ok = we && (wa != '0);

    // A new writer issued to the register being written back wins: the bit stays set.
    always_comb begin
        pend_nxt = pend;
        if (clr_ok)
            pend_nxt[wa] = 1'b0;
        if (set_ok)
            pend_nxt[issue_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    assign cnt_inc = set_ok && !pend[issue_addr];
    assign cnt_dec = clr_ok && pend[wa] && !(set_ok && (issue_addr == wa));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (clr_ok)
                regs[wa] <= wd;
            pend <= pend_nxt;
            if (cnt_inc && !cnt_dec)
                pend_cnt <= pend_cnt + 1'b1;
            else if (cnt_dec && !cnt_inc)
                pend_cnt <= pend_cnt - 1'b1;
        end
    end

    // Same-cycle write-back forwards its data and satisfies the hazard on that register.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a   = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit = we && (wa == a) && (a != '0);
        assign rd_data[k*DATA_W +: DATA_W] = (reset || (a == '0)) ? '0 :
                                             hit ? wd : regs[a];
        assign rd_pending[k] = !reset && pend[a] && !hit;
    end

`ifdef GRF_TRACE_EN
    logic [DATA_W-1:0] trace_wd;
    assign trace_wd = (wa == '0) ? '0 : wd;

    always_ff @(posedge clk) begin
        if (!reset && we)
            $display("%d@%h: $%d <= %h", $time, wpc, wa, trace_wd);
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_multiport_sb.sv
// tb/tb_grf_multiport_sb.sv - directed self-checking bench for grf_multiport_sb (4 read ports)
module tb_grf_multiport_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 4;

    logic                  clk;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_pending;
    logic                  issue_en;
    logic [ADDR_W-1:0]     issue_addr;
    logic                  we;
    logic [ADDR_W-1:0]     wa;
    logic [DATA_W-1:0]     wd;
    logic [31:0]           wpc;
    logic [ADDR_W:0]       pend_cnt;

    int n_checks;
    int n_fail;

    grf_multiport_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .wpc        (wpc),
        .pend_cnt   (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    function automatic logic [31:0] port_data(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        rd_addr    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        wpc        = 32'h0000_3000;
        repeat (3) step();
        reset = 1'b0;
        step();

        // reset state: every address on every port
        for (int a = 0; a < 32; a++) begin
            set_rd(a[4:0], a[4:0], a[4:0], a[4:0]);
            #1;
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("rst_data a%0d p%0d", a, k), port_data(k), 32'h0);
                check($sformatf("rst_pend a%0d p%0d", a, k), {31'b0, rd_pending[k]}, 32'h0);
            end
        end
        check("rst_cnt", {26'b0, pend_cnt}, 32'd0);

        // write $5 with same-cycle forwarding
        set_rd(5'd5, 5'd0, 5'd0, 5'd0);
        we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
        #1;
        check("fwd_w5", port_data(0), 32'h1234_5678);
        step();
        we = 1'b0;
        #1;
        check("stored_w5", port_data(0), 32'h1234_5678);

        // write to $0 is discarded, and never forwarded
        set_rd(5'd0, 5'd5, 5'd0, 5'd0);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        #1;
        check("fwd_w0", port_data(0), 32'h0);
        step();
        we = 1'b0;
        #1;
        check("stored_w0", port_data(0), 32'h0);
        check("w5_kept", port_data(1), 32'h1234_5678);

        // issue $8, then write it back
        set_rd(5'd8, 5'd9, 5'd0, 5'd0);
        issue_en = 1'b1; issue_addr = 5'd8;
        step();
        issue_en = 1'b0;
        #1;
        check("pend8_set", {31'b0, rd_pending[0]}, 32'h1);
        check("cnt_1", {26'b0, pend_cnt}, 32'd1);
        we = 1'b1; wa = 5'd8; wd = 32'h0000_0088;
        #1;
        check("pend8_wb_cycle", {31'b0, rd_pending[0]}, 32'h0);
        check("fwd_w8", port_data(0), 32'h0000_0088);
        step();
        we = 1'b0;
        #1;
        check("pend8_clr", {31'b0, rd_pending[0]}, 32'h0);
        check("cnt_0", {26'b0, pend_cnt}, 32'd0);

        // clearing an already-clear bit is a no-op
        we = 1'b1; wa = 5'd8; wd = 32'h0000_0089;
        step();
        we = 1'b0;
        #1;
        check("clr_noop_cnt", {26'b0, pend_cnt}, 32'd0);

        // re-issue $8, then issue and write-back $8 in the same cycle
        issue_en = 1'b1; issue_addr = 5'd8;
        step();
        check("cnt_reissue", {26'b0, pend_cnt}, 32'd1);
        we = 1'b1; wa = 5'd8; wd = 32'h0000_008A;
        #1;
        check("same_addr_wb_cycle", {31'b0, rd_pending[0]}, 32'h0);
        step();
        issue_en = 1'b0; we = 1'b0;
        #1;
        check("same_addr_pend8", {31'b0, rd_pending[0]}, 32'h1);
        check("same_addr_cnt", {26'b0, pend_cnt}, 32'd1);

        // issue $9 and write-back $8 in the same cycle
        issue_en = 1'b1; issue_addr = 5'd9;
        we = 1'b1; wa = 5'd8; wd = 32'h0000_008B;
        step();
        issue_en = 1'b0; we = 1'b0;
        #1;
        check("diff_addr_pend8", {31'b0, rd_pending[0]}, 32'h0);
        check("diff_addr_pend9", {31'b0, rd_pending[1]}, 32'h1);
        check("diff_addr_cnt", {26'b0, pend_cnt}, 32'd1);

        // issuing an already-pending register does not count twice
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        issue_en = 1'b0;
        #1;
        check("reissue9_cnt", {26'b0, pend_cnt}, 32'd1);

        // four ports, one hitting the in-flight write-back
        we = 1'b1; wa = 5'd3; wd = 32'h3333_3333;
        step();
        set_rd(5'd3, 5'd0, 5'd3, 5'd31);
        we = 1'b1; wa = 5'd31; wd = 32'hA5A5_A5A5;
        #1;
        check("p4_port0", port_data(0), 32'h3333_3333);
        check("p4_port1", port_data(1), 32'h0);
        check("p4_port2", port_data(2), 32'h3333_3333);
        check("p4_port3", port_data(3), 32'hA5A5_A5A5);
        step();
        we = 1'b0;
        #1;
        check("p4_stored31", port_data(3), 32'hA5A5_A5A5);

        // build up three pending registers
        issue_en = 1'b1; issue_addr = 5'd10;
        step();
        issue_addr = 5'd11;
        step();
        issue_en = 1'b0;
        set_rd(5'd3, 5'd9, 5'd10, 5'd11);
        #1;
        check("cnt_3", {26'b0, pend_cnt}, 32'd3);
        check("pend9_before_rst", {31'b0, rd_pending[1]}, 32'h1);

        // asynchronous reset mid-cycle, with a write-back on the bus
        we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF;
        #1;
        reset = 1'b1;
        #1;
        check("arst_data_p0", port_data(0), 32'h0);
        check("arst_pend", {28'b0, rd_pending}, 32'h0);
        check("arst_cnt", {26'b0, pend_cnt}, 32'd0);
        step();
        we = 1'b0;
        #1;
        reset = 1'b0;
        set_rd(5'd3, 5'd5, 5'd31, 5'd9);
        #1;
        check("post_rst_r3", port_data(0), 32'h0);
        check("post_rst_r5", port_data(1), 32'h0);
        check("post_rst_r31", port_data(2), 32'h0);
        check("post_rst_pend", {28'b0, rd_pending}, 32'h0);
        step();
        check("post_rst_cnt", {26'b0, pend_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
